// File: rtl/buscaminas_pkg.sv
// Shared board geometry, placer state encoding and cell helpers for the Buscaminas datapath.
// neighbour_count is also used by the game FSM's reveal logic.
package buscaminas_pkg;

  localparam int unsigned BOARD_W     = 8;
  localparam int unsigned BOARD_CELLS = 64;
  localparam logic [3:0]  NO_CLICK    = 4'hF;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLACE,
    ST_COUNT,
    ST_DONE
  } placer_state_t;

  function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

  // Mines among the up to 8 in-bounds neighbours; no wrap across edges.
  function automatic logic [3:0] neighbour_count(input logic [63:0] bombs, input logic [5:0] idx);
    logic [3:0] n;
    int cx, cy, nx, ny;
    n  = '0;
    cx = int'(idx[2:0]);
    cy = int'(idx[5:3]);
    for (int unsigned dy = 0; dy < 3; dy++) begin
      for (int unsigned dx = 0; dx < 3; dx++) begin
        nx = cx + int'(dx) - 1;
        ny = cy + int'(dy) - 1;
        if ((dx != 1 || dy != 1) && nx >= 0 && nx < int'(BOARD_W) &&
            ny >= 0 && ny < int'(BOARD_W))
          n = n + 4'(bombs[6'(ny * int'(BOARD_W) + nx)]);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, right-shifting, free running; an all-zero seed is replaced by 1.
module lfsr16
  import buscaminas_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= INIT;
    else if (q[0])
      q <= (q >> 1) ^ LFSR_TAPS;
    else
      q <= q >> 1;
  end

endmodule

// File: rtl/bomb_placer.sv
// Builds a random 8x8 mine field with NUM_BOMBS mines (optionally sparing one cell),
// then fills in the per-cell neighbour counts one cell per cycle.
module bomb_placer
  import buscaminas_pkg::*;
#(
  parameter int unsigned NUM_BOMBS = 10,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   safe_x,
  input  logic [3:0]   safe_y,
  output logic [63:0]  bombs,
  output logic [255:0] counts,
  output logic         busy,
  output logic         done,
  output logic         valid
);

  if (NUM_BOMBS < 1 || NUM_BOMBS > 63) begin : g_bad_num_bombs
    $error("bomb_placer: NUM_BOMBS must be in 1..63");
  end

  placer_state_t state, next_state;

  logic [15:0] lfsr_q;
  logic [9:0]  lfsr_unused;
  logic [5:0]  cand;
  logic [5:0]  placed;
  logic [5:0]  cur_cell;
  logic [5:0]  safe_idx;
  logic        safe_en;
  logic        accept, place_hit, place_last;
  logic        busy_d, done_d, valid_d;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign cand        = lfsr_q[5:0];
  assign lfsr_unused = lfsr_q[15:6];

  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign place_hit  = !bombs[cand] && !(safe_en && cand == safe_idx);
  assign place_last = place_hit && (placed + 6'd1 == 6'(NUM_BOMBS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_CLEAR;
      ST_CLEAR:         next_state = ST_PLACE;
      ST_PLACE:         if (place_last) next_state = ST_COUNT;
      ST_COUNT:         if (cur_cell == 6'(BOARD_CELLS - 1)) next_state = ST_DONE;
      default:          next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (next_state == ST_CLEAR) || (next_state == ST_PLACE) || (next_state == ST_COUNT);
    done_d  = (state == ST_COUNT) && (next_state == ST_DONE);
    valid_d = (next_state == ST_DONE);
  end

  // The clear and safe-cell latch happen on the edge that enters CLEAR, so the
  // registered outputs already read zero throughout the CLEAR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bombs    <= '0;
      counts   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      placed   <= '0;
      cur_cell <= '0;
      safe_idx <= '0;
      safe_en  <= 1'b0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      valid <= valid_d;
      if (accept) begin
        bombs    <= '0;
        counts   <= '0;
        placed   <= '0;
        cur_cell <= '0;
        safe_en  <= !safe_x[3] && !safe_y[3];
        safe_idx <= cell_idx(safe_x[2:0], safe_y[2:0]);
      end else if (state == ST_PLACE && place_hit) begin
        bombs[cand] <= 1'b1;
        placed      <= placed + 6'd1;
      end else if (state == ST_COUNT) begin
        counts[{cur_cell, 2'b00} +: 4] <= neighbour_count(bombs, cur_cell);
        cur_cell                       <= cur_cell + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_bomb_placer.sv
// Scoreboard bench for bomb_placer: two instances (10 mines free, 63 mines with a safe cell).
module tb_bomb_placer;
  import buscaminas_pkg::*;

  localparam int unsigned NB_A   = 10;
  localparam int unsigned NB_B   = 63;
  localparam logic [15:0] SEED_A = 16'hACE1;
  localparam logic [15:0] SEED_B = 16'h1D2C;
  localparam int unsigned BUDGET = 20000;

  typedef struct {
    logic [63:0]  bombs;
    logic [255:0] counts;
    int unsigned  lat;
    int unsigned  t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [3:0] sx_a = NO_CLICK, sy_a = NO_CLICK, sx_b = NO_CLICK, sy_b = NO_CLICK;
  logic [63:0]  bombs_a, bombs_b;
  logic [255:0] counts_a, counts_b;
  logic busy_a, busy_b, done_a, done_b, valid_a, valid_b;

  int unsigned cyc = 0, checks = 0, errors = 0, gaps_a = 0, gaps_b = 0;
  logic [15:0] m_a, m_b;
  exp_t q_a[$], q_b[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  bomb_placer #(.NUM_BOMBS(NB_A), .SEED(SEED_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .safe_x(sx_a), .safe_y(sy_a),
    .bombs(bombs_a), .counts(counts_a), .busy(busy_a), .done(done_a), .valid(valid_a)
  );

  bomb_placer #(.NUM_BOMBS(NB_B), .SEED(SEED_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .safe_x(sx_b), .safe_y(sy_b),
    .bombs(bombs_b), .counts(counts_b), .busy(busy_b), .done(done_b), .valid(valid_b)
  );

  function automatic logic [15:0] step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [63:0] b);
    int unsigned n = 0;
    for (int i = 0; i < 64; i++) if (b[i]) n++;
    return n;
  endfunction

  function automatic logic [255:0] ref_counts(input logic [63:0] b);
    logic [255:0] r = '0;
    int n;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int yy = y - 1; yy <= y + 1; yy++)
          for (int xx = x - 1; xx <= x + 1; xx++)
            if (yy >= 0 && yy < 8 && xx >= 0 && xx < 8 && !(yy == y && xx == x) &&
                b[6'(yy * 8 + xx)])
              n++;
        r[8'((y * 8 + x) * 4) +: 4] = 4'(n);
      end
    return r;
  endfunction

  // l0 is the LFSR value during the start cycle; PLACE begins two steps later.
  function automatic exp_t predict(input logic [15:0] l0, input int unsigned n,
                                   input logic [3:0] sx, input logic [3:0] sy,
                                   input int unsigned t0);
    exp_t e;
    logic [15:0] l;
    logic [5:0] c, si;
    logic se;
    int unsigned placed = 0, p = 0;
    se = (sx < 4'd8) && (sy < 4'd8);
    si = 6'(int'(sy) * 8 + int'(sx));
    e.bombs = '0;
    l = step(step(l0));
    while (placed < n && p < 100000) begin
      c = l[5:0];
      p++;
      if (!e.bombs[c] && !(se && c == si)) begin
        e.bombs[c] = 1'b1;
        placed++;
      end
      l = step(l);
    end
    e.counts = ref_counts(e.bombs);
    e.lat    = 2 + p + 64;
    e.t0     = t0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [63:0] b,
                       input logic [255:0] c, input logic bz, input logic v,
                       input int unsigned nb, input int unsigned gaps);
    chk({tag, "_bombs"},   256'(b), 256'(e.bombs));
    chk({tag, "_counts"},  c, e.counts);
    chk({tag, "_latency"}, 256'(cyc - e.t0), 256'(e.lat));
    chk({tag, "_popcount"}, 256'(popcount(b)), 256'(nb));
    chk({tag, "_valid"},   256'(v), 256'(1));
    chk({tag, "_busy_low_at_done"}, 256'(bz), 256'(0));
    chk({tag, "_busy_gaps"}, 256'(gaps), 256'(0));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a <= SEED_A;
      m_b <= SEED_B;
    end else begin
      m_a <= step(m_a);
      m_b <= step(m_b);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (done_a) begin
        chk("a_done_expected", 256'(q_a.size() != 0), 256'(1));
        if (q_a.size() != 0) begin
          ea = q_a.pop_front();
          score("a", ea, bombs_a, counts_a, busy_a, valid_a, NB_A, gaps_a);
        end
        gaps_a = 0;
      end else if (q_a.size() != 0 && cyc > q_a[0].t0 && !busy_a) begin
        gaps_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (done_b) begin
        chk("b_done_expected", 256'(q_b.size() != 0), 256'(1));
        if (q_b.size() != 0) begin
          eb = q_b.pop_front();
          score("b", eb, bombs_b, counts_b, busy_b, valid_b, NB_B, gaps_b);
        end
        gaps_b = 0;
      end else if (q_b.size() != 0 && cyc > q_b[0].t0 && !busy_b) begin
        gaps_b++;
      end
    end
  end

  task automatic issue(input int which, input logic [3:0] sx, input logic [3:0] sy);
    @(negedge clk);
    if (which == 0) begin
      sx_a = sx; sy_a = sy; start_a = 1'b1;
      q_a.push_back(predict(m_a, NB_A, sx, sy, cyc));
    end else begin
      sx_b = sx; sy_b = sy; start_b = 1'b1;
      q_b.push_back(predict(m_b, NB_B, sx, sy, cyc));
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input int which, input string tag);
    int unsigned left;
    left = (which == 0) ? q_a.size() : q_b.size();
    for (int i = 0; i < BUDGET && left != 0; i++) begin
      @(negedge clk);
      left = (which == 0) ? q_a.size() : q_b.size();
    end
    chk({tag, "_drain_timeout"}, 256'(left), 256'(0));
    if (which == 0) q_a.delete(); else q_b.delete();
  endtask

  task automatic wait_cyc(input int unsigned tgt, input string tag);
    for (int i = 0; i < BUDGET && cyc < tgt; i++) @(negedge clk);
    chk({tag, "_reached"}, 256'(cyc == tgt), 256'(1));
  endtask

  initial begin
    int unsigned tgt;
    bit got;

    repeat (3) @(negedge clk);
    chk("rst_bombs",  256'(bombs_a), 256'(0));
    chk("rst_counts", counts_a, 256'(0));
    chk("rst_busy",   256'(busy_a), 256'(0));
    chk("rst_done",   256'(done_a), 256'(0));
    chk("rst_valid",  256'(valid_a), 256'(0));
    reset = 1'b1;

    // 63 mines, (3,4) spared: every cell but idx 35 is a mine
    issue(1, 4'd3, 4'd4);
    drain(1, "b_safe");
    chk("b_safe_bombs_const", 256'(bombs_b), 256'(64'hFFFF_FFF7_FFFF_FFFF));
    chk("b_safe_count35",     256'(counts_b[143:140]), 256'(8));
    chk("b_corner_count0",    256'(counts_b[3:0]), 256'(3));
    chk("b_corner_count63",   256'(counts_b[255:252]), 256'(3));

    issue(0, NO_CLICK, NO_CLICK);
    drain(0, "a_basic");

    // second start five cycles into PLACE must be ignored
    issue(0, NO_CLICK, NO_CLICK);
    wait_cyc(q_a[0].t0 + 7, "a_guard");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain(0, "a_guard");

    // start on the done cycle
    issue(0, 4'd9, 4'd2);
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      if (done_a) got = 1'b1;
    end
    chk("a_rebuild_done_seen", 256'(got), 256'(1));
    start_a = 1'b1;
    q_a.push_back(predict(m_a, NB_A, 4'd9, 4'd2, cyc));
    @(negedge clk);
    start_a = 1'b0;
    chk("a_rebuild_valid_drop", 256'(valid_a), 256'(0));
    drain(0, "a_rebuild");

    // reset while counting cell 20
    issue(0, 4'd0, 4'd0);
    tgt = q_a[0].t0 + q_a[0].lat - 44;
    wait_cyc(tgt, "a_midcount");
    #2 reset = 1'b0;
    q_a.delete();
    #1;
    chk("midrst_bombs",  256'(bombs_a), 256'(0));
    chk("midrst_counts", counts_a, 256'(0));
    chk("midrst_busy",   256'(busy_a), 256'(0));
    chk("midrst_done",   256'(done_a), 256'(0));
    chk("midrst_valid",  256'(valid_a), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_idle_busy",  256'(busy_a), 256'(0));
    chk("midrst_idle_valid", 256'(valid_a), 256'(0));
    issue(0, 4'd7, 4'd7);
    drain(0, "a_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/bomb_placer.md
Name: bomb_placer

Overview:
Upstream stage of the Buscaminas game FSM. On request, it generates a random 8x8 mine field with exactly NUM_BOMBS mines and optionally keeps one "safe" cell (the player's first click) mine-free. It then computes the 0..8 neighbour-mine count for every cell. It drives the 64-bit bombs vector consumed by the game FSM and a packed counts vector for the display/reveal logic.

Parameters:
NUM_BOMBS, 10, number of mines placed; legal range 1..63; elaboration error outside that range.
SEED, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'h0001.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to build a new field; ignored while busy=1
safe_x  input  4  column of the cell kept mine-free; 4'hF = no exclusion
safe_y  input  4  row of the cell kept mine-free; 4'hF = no exclusion
bombs  output  64  mine map, bit index = y*8+x; 1 = mine
counts  output  256  neighbour count per cell, counts[idx*4 +: 4], values 0..8
busy  output  1  high from the cycle after start accepted until done
done  output  1  one-cycle pulse when field and counts are complete
valid  output  1  level; high from done until next accepted start or reset

Behaviour:
- Reset (async, active-low): state=IDLE; bombs=0, counts=0; busy=0, done=0, valid=0; placed=0; LFSR=SEED.
- LFSR: 16-bit Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1). Advances every clk in every state, so field content depends on start timing. Candidate index = lfsr[5:0].
- States: IDLE, CLEAR, PLACE, COUNT, DONE.
- IDLE/DONE: when start=1, go to CLEAR and drop valid the next cycle. Otherwise hold.
- CLEAR (1 cycle):
  - bombs=0, counts=0, placed=0, cell_idx=0, busy=1.
  - Latch safe_idx = safe_y[2:0]*8+safe_x[2:0] only when both safe_x and safe_y are <8; otherwise no exclusion.
  - Go to PLACE.
- PLACE (one candidate per cycle):
  - If bombs[cand]==0 and cand is not safe_idx: set bombs[cand], placed++.
  - Otherwise discard the candidate; placed is unchanged.
  - When placed reaches NUM_BOMBS (evaluated on the post-increment value), go to COUNT.
  - Minimum NUM_BOMBS cycles. The LFSR visits every 6-bit index within its period, so termination is guaranteed.
- COUNT (exactly 64 cycles, cell_idx 0..63):
  - counts[cell_idx] = popcount of the up to 8 in-bounds neighbours; no wrap across row/column edges; the cell itself is excluded.
  - Corner cells have 3 neighbours, edge cells 5, interior cells 8.
  - After cell_idx=63, go to DONE.
- DONE: on entry, done=1 for exactly one cycle, busy=0, valid=1. bombs/counts are held stable until the next accepted start.
- Latency: start at cycle T, CLEAR at T+1, PLACE from T+2 lasting P>=NUM_BOMBS cycles, COUNT 64 cycles, done at T+2+P+64.
- start while busy=1: ignored; no restart, no queueing.
- start on the same cycle done is asserted: accepted (state is DONE).
- safe_x or safe_y in the range 8..14: treated as no exclusion.
- Reset mid-PLACE or mid-COUNT: immediate return to reset values; no partial field is flagged valid.
- Outputs are registered and change only on clk edges, except under asynchronous reset.

Decomposition:
- buscaminas_pkg:
  - BOARD_W=8, BOARD_CELLS=64, NO_CLICK=4'hF, LFSR_TAPS=16'hB400.
  - placer_state_t enum.
  - Function cell_idx(x,y).
  - Function neighbour_count(bombs, idx), shared with the game FSM's reveal logic.
- Sub-module lfsr16 (clk, reset, seed parameter, q[15:0]).

Test Plan:
- Reset: assert reset=0 mid-simulation -> bombs=0, counts=0, busy=0, done=0, valid=0 immediately, without waiting for clk.
- Basic build: NUM_BOMBS=10, SEED=16'hACE1, start pulse, safe=4'hF/4'hF -> done pulses exactly once; popcount(bombs)=10; busy high throughout; every counts nibble matches the bench reference model; cycles from start to done = 2+P+64, with P checked against the model LFSR.
- Safe cell: safe_x=3, safe_y=4 and NUM_BOMBS=63 -> bombs = 64'hFFFF_FFFF_FFFF_FFFF with bit 35 cleared; counts[35]=8; corner counts[0]=3.
- Busy guard: second start pulse 5 cycles into PLACE -> ignored; done pulses once; popcount unchanged at NUM_BOMBS.
- Reset mid-COUNT: reset=0 at cell_idx=20, then release -> all outputs 0, state IDLE; a new start yields a full valid field.
- Rebuild: start on the done cycle -> valid drops the next cycle; new field completes with popcount=NUM_BOMBS; no done pulse between the two builds.
